m_cache_refill: RTL
===================

# m_cache_refill

Line-refill engine for the write-noallocate data cache: on a read miss it fetches the 4-word (128-bit) line containing the miss address from main memory, one 32-bit word per beat, assembles it, and drives the cache's install port (install enable, install address, 128-bit install data). It sits between the cache's miss/install side and the memory port. It guarantees that an install never coincides with a cache write-through, which the cache forbids.

## Interface
Parameters:
- none; address width comes from `DADDR / `DADDR_WIDTH in define.v

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_miss  in  1  read-miss request; sampled only in IDLE
- i_miss_addr  in  `DADDR  miss address; bits [3:0] ignored
- o_busy  out  1  high in every state except IDLE
- o_mem_req  out  1  memory read request valid
- o_mem_addr  out  `DADDR  word address of the current request (line base + 4·k)
- i_mem_gnt  in  1  memory accepted the request this cycle
- i_mem_rvalid  in  1  read data beat valid; beats return in request order
- i_mem_rdata  in  32  read data
- i_wr_pending  in  1  a cache write is in flight (cache write enable or its delayed copy); blocks install
- o_ie  out  1  install enable to the cache, single-cycle pulse
- o_iaddr  out  `DADDR  install address; bits [3:0] = 0
- o_idata  out  128  assembled line; word k in bits [32k+31:32k]
- o_done  out  1  refill complete; pulses in the same cycle as o_ie

## Operation
- States: IDLE, FILL, INSTALL.
- IDLE: i_miss=1 → latch {i_miss_addr[`DADDR_WIDTH-1:4], 4'b0} as the line base, clear counters, go to FILL.
- FILL: two 3-bit counters, req_cnt and rsp_cnt (range 0..4).
  - o_mem_req=1 while req_cnt<4; o_mem_addr = base + 4·req_cnt; req_cnt increments on i_mem_gnt.
  - On i_mem_rvalid with rsp_cnt<req_cnt: store i_mem_rdata in word rsp_cnt, then increment rsp_cnt.
  - rsp_cnt reaching 4 → INSTALL.
- INSTALL: if i_wr_pending=0 → o_ie=1, o_done=1, go to IDLE; otherwise hold, with o_ie=0 and o_idata/o_iaddr stable.
- i_miss outside IDLE is ignored; the requester must hold it until o_busy falls.
- i_mem_rvalid with no outstanding request (rsp_cnt==req_cnt, or in IDLE/INSTALL) is discarded.
- o_iaddr and o_idata remain valid from INSTALL entry until the next miss is accepted.

## Timing
- Reset values: o_busy=0, o_mem_req=0, o_mem_addr=0, o_ie=0, o_iaddr=0, o_idata=0, o_done=0; state IDLE, counters 0.
- All outputs are registered or decoded from state/counters. No combinational path from i_mem_* to o_ie.
- Cycle 0: miss accepted. Cycle 1: first o_mem_req. With gnt every cycle and rvalid one cycle after gnt, requests go out in cycles 1–4 and data arrives in cycles 2–5. INSTALL is entered in cycle 6 and o_ie fires in cycle 6. Minimum miss-to-install latency is 6 cycles.
- Back-to-back misses: a new miss can be accepted in the cycle after o_ie.
- Reset mid-FILL or mid-INSTALL: return to IDLE the next cycle with no o_ie. Late beats that arrive afterwards are discarded.
- i_wr_pending held high indefinitely: remain in INSTALL. There is no timeout.

## Structure
- define.v: `DADDR and `DADDR_WIDTH (existing). Add `LINE_WORDS=4 and the state encodings `RF_IDLE, `RF_FILL, `RF_INSTALL.
- One sub-module, m_line_assembler: 4×32-bit word registers with a write strobe, a 2-bit word index, synchronous clear, and a 128-bit output. The FSM stays in m_cache_refill.

## Test plan
- Basic: miss at 0x0000_1234, gnt always 1, rvalid one cycle after gnt with data 0xA0..0xA3 → mem addrs 0x1230/34/38/3C; o_ie in cycle 6; o_iaddr=0x1230; o_idata=0x000000A3_000000A2_000000A1_000000A0.
- Backpressure: gnt toggles 1,0,1,0…; rvalid delayed by 3 cycles → all four addresses issued once each, line correct, o_done coincides with o_ie.
- Write collision: i_wr_pending=1 for 5 cycles after INSTALL entry → o_ie is never high while i_wr_pending=1; o_ie fires in the first cycle it is low; o_idata is unchanged throughout.
- Reset mid-FILL after 2 beats, then 2 stray rvalids, then a new miss at 0x40 → no o_ie before the new miss; the stray beats are discarded; second line installed at 0x40 with the correct data.
- Ignored inputs: i_miss pulsed during FILL, and rvalid while IDLE → no extra memory requests; o_busy stays low after o_done; exactly one o_ie per accepted miss.

Source files
------------

// File: rtl/m_cache_refill_pkg.sv
// Shared types and constants for the data-cache line-refill engine.
package m_cache_refill_pkg;

  localparam int unsigned DaddrWidth = 32;
  localparam int unsigned LineWords  = 4;
  localparam int unsigned WordWidth  = 32;
  localparam int unsigned LineWidth  = LineWords * WordWidth;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFill    = 2'd1,
    StInstall = 2'd2
  } rf_state_e;

  // Line-aligned base of an arbitrary byte address (16-byte lines).
  function automatic logic [DaddrWidth-1:0] line_base(input logic [DaddrWidth-1:0] addr);
    return {addr[DaddrWidth-1:4], 4'b0000};
  endfunction

endpackage

// File: rtl/m_line_assembler.sv
// Four 32-bit word registers collecting a cache line beat by beat.
module m_line_assembler
  import m_cache_refill_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 clr_i,
  input  logic                 we_i,
  input  logic [1:0]           idx_i,
  input  logic [WordWidth-1:0] wdata_i,
  output logic [LineWidth-1:0] line_o
);

  logic [WordWidth-1:0] word_q [LineWords];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int k = 0; k < LineWords; k++) begin
        word_q[k] <= '0;
      end
    end else if (we_i) begin
      word_q[idx_i] <= wdata_i;
    end
  end

  always_comb begin
    line_o = '0;
    for (int k = 0; k < LineWords; k++) begin
      line_o[k*WordWidth +: WordWidth] = word_q[k];
    end
  end

endmodule

// File: rtl/m_cache_refill.sv
// Read-miss line refill: fetches four words, assembles the line and installs it
// only when no cache write-through is in flight.
module m_cache_refill
  import m_cache_refill_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_miss,
  input  logic [DaddrWidth-1:0] i_miss_addr,
  output logic                  o_busy,
  output logic                  o_mem_req,
  output logic [DaddrWidth-1:0] o_mem_addr,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [WordWidth-1:0]  i_mem_rdata,
  input  logic                  i_wr_pending,
  output logic                  o_ie,
  output logic [DaddrWidth-1:0] o_iaddr,
  output logic [LineWidth-1:0]  o_idata,
  output logic                  o_done
);

  rf_state_e             state_q, state_d;
  logic [2:0]            req_cnt_q, req_cnt_d;
  logic [2:0]            rsp_cnt_q, rsp_cnt_d;
  logic [DaddrWidth-1:0] base_q, base_d;
  logic                  accept;
  logic                  beat_we;

  assign o_busy     = (state_q != StIdle);
  assign o_mem_req  = (state_q == StFill) && (req_cnt_q < 3'(LineWords));
  assign o_mem_addr = base_q + DaddrWidth'({req_cnt_q, 2'b00});
  // Install is gated only by state and the write-pending flag, never by memory inputs.
  assign o_ie       = (state_q == StInstall) && !i_wr_pending;
  assign o_done     = o_ie;
  assign o_iaddr    = base_q;

  always_comb begin
    state_d   = state_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    base_d    = base_q;
    accept    = 1'b0;
    beat_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_miss) begin
          accept    = 1'b1;
          base_d    = line_base(i_miss_addr);
          req_cnt_d = '0;
          rsp_cnt_d = '0;
          state_d   = StFill;
        end
      end
      StFill: begin
        if (o_mem_req && i_mem_gnt) begin
          req_cnt_d = req_cnt_q + 3'd1;
        end
        // Beats with nothing outstanding are dropped.
        if (i_mem_rvalid && (rsp_cnt_q < req_cnt_q)) begin
          beat_we   = 1'b1;
          rsp_cnt_d = rsp_cnt_q + 3'd1;
        end
        if (rsp_cnt_d == 3'(LineWords)) begin
          state_d = StInstall;
        end
      end
      StInstall: begin
        if (!i_wr_pending) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      base_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      base_q    <= base_d;
    end
  end

  m_line_assembler u_line (
    .clk_i   (i_clk),
    .clr_i   (i_rst | accept),
    .we_i    (beat_we),
    .idx_i   (rsp_cnt_q[1:0]),
    .wdata_i (i_mem_rdata),
    .line_o  (o_idata)
  );

endmodule
